work_dispatcher: RTL
====================

// Module: work_dispatcher
// PURPOSE
//   Cluster-side end of the miner serial link. Serializes one 512-bit work unit
//   (midstate, data2) as 64 UART 8N1 bytes onto a miner's serial input. Also
//   deserializes the 4-byte golden nonces that the miner returns on its serial
//   output. One instance per miner in the cluster; TX and RX paths run fully
//   independently (full duplex).
// PARAMETERS
//   CLK_HZ      50_000_000  hash_clk frequency in Hz
//   BAUD        115_200     line rate; DIV = CLK_HZ/BAUD (truncated), DIV >= 4 required
//   GAP_CYCLES  DIV*40      max idle cycles between nonce bytes before partial frame is dropped
// PORTS
//   hash_clk      in   1    clock
//   reset_n       in   1    asynchronous, active-low reset
//   work_data     in   512  [511:256] midstate, [255:0] data2
//   work_valid    in   1    work_data valid; producer holds until accepted
//   work_ready    out  1    dispatcher can accept work this cycle
//   ser_txd       out  1    UART out, drives miner RxD; idle high
//   ser_rxd       in   1    UART in, from miner TxD; asynchronous to hash_clk
//   nonce         out  32   last golden nonce received
//   nonce_valid   out  1    one-cycle pulse, nonce updated
//   rx_frame_err  out  1    one-cycle pulse, bad stop bit detected
// BEHAVIOUR
//   Reset: ser_txd=1, work_ready=1, nonce=0, nonce_valid=0, rx_frame_err=0, both FSMs idle.
//   Reset is async in both directions: an in-flight byte is abandoned and ser_txd goes high at once.
//   TX FSM: T_IDLE -> T_START -> T_DATA -> T_STOP -> (T_START | T_IDLE).
//   - Accept when work_valid && work_ready; load 512-bit shift reg, byte_cnt=0, work_ready=0 next cycle.
//   - Byte order MSB byte first: work_data[511:504] first, [7:0] last. Bits LSB first within each byte.
//   - Each bit held exactly DIV cycles. One stop bit, then next start bit immediately, no gap.
//   - Frame is 64*10*DIV cycles. work_ready returns to 1 on the cycle after the 64th stop bit ends.
//   - work_valid while work_ready=0 is ignored (no queueing).
//   RX FSM: R_IDLE -> R_START -> R_DATA -> R_STOP -> R_IDLE; plus R_WAIT_HI after error.
//   - ser_rxd passes through a 2-flop synchronizer; all sampling uses the synchronized value.
//   - R_IDLE: sync falling edge -> R_START. After DIV/2 cycles, re-sample:
//     low -> R_DATA; high -> glitch, back to R_IDLE.
//   - 8 data samples, one every DIV cycles, LSB first; stop sample DIV cycles after bit 7.
//   - Stop bit high: byte accepted into slot byte_idx (0..3), byte_idx++.
//   - Stop bit low: rx_frame_err pulse, byte dropped, byte_idx=0, then R_WAIT_HI until
//     line is sampled high, then R_IDLE.
//   - Nonce byte order LSB first: bytes b0,b1,b2,b3 -> nonce={b3,b2,b1,b0}.
//     On 4th byte accept: nonce loaded and nonce_valid=1 in the same cycle, byte_idx wraps to 0.
//   - Gap timer: cleared on each accepted byte and counts while byte_idx!=0 in R_IDLE.
//     At GAP_CYCLES: byte_idx=0 (partial dropped, no error pulse).
//   - nonce holds its value between pulses. Back-to-back nonces are each pulsed; none are lost.
//   Simultaneous TX accept and RX events do not interact. All counters saturate or wrap only as stated.
// TESTING (sim with CLK_HZ=16, BAUD=1 -> DIV=16, GAP_CYCLES=640)
//   1 work_data={256'h2b3f8126..b5, 256'h..39f3001b6b7b8d4dc14bfc31} accepted ->
//     first byte 0x2b, last byte 0x31 on ser_txd, each bit 16 cycles.
//     work_ready low 1 cycle after accept, high again 10240 cycles later.
//   2 ser_rxd bytes 0x78,0x56,0x34,0x12 (8N1, DIV=16) -> nonce=32'h12345678,
//     single nonce_valid pulse at the 4th stop sample.
//   3 byte 0xAA with stop bit low -> rx_frame_err pulse, no nonce_valid.
//     Next 4 good bytes 0xEF,0xBE,0xAD,0xDE -> nonce=32'hDEADBEEF.
//   4 bytes 0x01,0x02, idle 641 cycles, then 0x78,0x56,0x34,0x12 -> exactly one nonce_valid, nonce=32'h12345678.
//   5 ser_rxd low pulse of 4 cycles -> no byte received, RX stays idle, no error pulse.
//   6 reset_n low during 10th TX byte -> ser_txd=1 immediately, work_ready=1 after release.
//     New work starts at byte 0 (its [511:504]).

Source files
------------

// File: rtl/work_dispatcher.sv
// Miner serial link endpoint: ships 512-bit work units out as 64 UART 8N1 bytes
// and collects 4-byte golden nonces coming back. TX and RX run independently.
module work_dispatcher #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned GAP_CYCLES = (CLK_HZ / BAUD) * 40
) (
    input  logic         hash_clk,
    input  logic         reset_n,
    input  logic [511:0] work_data,
    input  logic         work_valid,
    output logic         work_ready,
    output logic         ser_txd,
    input  logic         ser_rxd,
    output logic [31:0]  nonce,
    output logic         nonce_valid,
    output logic         rx_frame_err
);

    // Cycles per bit; must be at least 4 so the half-bit start check is meaningful.
    localparam int unsigned Div  = CLK_HZ / BAUD;
    localparam int unsigned TmrW = (Div > 1) ? $clog2(Div) : 1;
    localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

    localparam logic [TmrW-1:0] BitLast  = TmrW'(Div - 1);
    localparam logic [TmrW-1:0] HalfLast = TmrW'(Div / 2 - 1);
    localparam logic [GapW-1:0] GapLast  = GapW'(GAP_CYCLES - 1);

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        TIdle,
        TStart,
        TData,
        TStop
    } tx_state_e;

    tx_state_e        tx_state_q, tx_state_d;
    logic [TmrW-1:0]  tx_tmr_q, tx_tmr_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [5:0]       tx_byte_q, tx_byte_d;
    logic [511:0]     tx_sh_q, tx_sh_d;
    logic [7:0]       tx_cur_byte;
    logic             tx_bit_done;

    // TX next-state and line drive; the byte in flight always sits in the top 8 bits.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_tmr_d    = tx_tmr_q;
        tx_bit_d    = tx_bit_q;
        tx_byte_d   = tx_byte_q;
        tx_sh_d     = tx_sh_q;
        tx_cur_byte = tx_sh_q[511:504];
        tx_bit_done = (tx_tmr_q == BitLast);
        work_ready  = (tx_state_q == TIdle);
        ser_txd     = 1'b1;

        unique case (tx_state_q)
            TIdle: begin
                if (work_valid) begin
                    tx_sh_d    = work_data;
                    tx_byte_d  = '0;
                    tx_tmr_d   = '0;
                    tx_state_d = TStart;
                end
            end
            TStart: begin
                ser_txd  = 1'b0;
                tx_tmr_d = tx_bit_done ? '0 : tx_tmr_q + 1'b1;
                if (tx_bit_done) begin
                    tx_bit_d   = '0;
                    tx_state_d = TData;
                end
            end
            TData: begin
                ser_txd  = tx_cur_byte[tx_bit_q];
                tx_tmr_d = tx_bit_done ? '0 : tx_tmr_q + 1'b1;
                if (tx_bit_done) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TStop;
                    end else begin
                        tx_bit_d = tx_bit_q + 3'd1;
                    end
                end
            end
            TStop: begin
                ser_txd  = 1'b1;
                tx_tmr_d = tx_bit_done ? '0 : tx_tmr_q + 1'b1;
                if (tx_bit_done) begin
                    if (tx_byte_q == 6'd63) begin
                        tx_state_d = TIdle;
                    end else begin
                        // Next start bit follows the stop bit with no idle gap.
                        tx_byte_d  = tx_byte_q + 6'd1;
                        tx_sh_d    = tx_sh_q << 8;
                        tx_state_d = TStart;
                    end
                end
            end
            default: tx_state_d = TIdle;
        endcase
    end

    // TX state registers; async reset drops any in-flight byte and idles the line.
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q <= TIdle;
            tx_tmr_q   <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
            tx_sh_q    <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tmr_q   <= tx_tmr_d;
            tx_bit_q   <= tx_bit_d;
            tx_byte_q  <= tx_byte_d;
            tx_sh_q    <= tx_sh_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RIdle,
        RStart,
        RData,
        RStop,
        RWaitHi
    } rx_state_e;

    rx_state_e        rx_state_q, rx_state_d;
    logic [1:0]       rx_sync_q;
    logic             rxd_prev_q;
    logic             rxd_s;
    logic [TmrW-1:0]  rx_tmr_q, rx_tmr_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic [1:0]       rx_idx_q, rx_idx_d;
    logic [23:0]      rx_acc_q, rx_acc_d;
    logic [GapW-1:0]  rx_gap_q, rx_gap_d;
    logic [31:0]      nonce_q, nonce_d;
    logic             nonce_valid_q, nonce_valid_d;
    logic             frame_err_q, frame_err_d;

    assign rxd_s = rx_sync_q[1];

    // RX next-state: start validation, mid-bit sampling, nonce assembly and gap timeout.
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_tmr_d      = rx_tmr_q;
        rx_bit_d      = rx_bit_q;
        rx_sh_d       = rx_sh_q;
        rx_idx_d      = rx_idx_q;
        rx_acc_d      = rx_acc_q;
        rx_gap_d      = rx_gap_q;
        nonce_d       = nonce_q;
        nonce_valid_d = 1'b0;
        frame_err_d   = 1'b0;

        unique case (rx_state_q)
            RIdle: begin
                // A partially received nonce is abandoned if the line stays quiet too long.
                if (rx_idx_q != 2'd0) begin
                    if (rx_gap_q == GapLast) begin
                        rx_idx_d = '0;
                        rx_gap_d = '0;
                    end else begin
                        rx_gap_d = rx_gap_q + 1'b1;
                    end
                end
                if (rxd_prev_q && !rxd_s) begin
                    rx_tmr_d   = '0;
                    rx_state_d = RStart;
                end
            end
            RStart: begin
                if (rx_tmr_q == HalfLast) begin
                    rx_tmr_d = '0;
                    if (!rxd_s) begin
                        rx_bit_d   = '0;
                        rx_state_d = RData;
                    end else begin
                        // Low pulse shorter than half a bit: treat as noise.
                        rx_state_d = RIdle;
                    end
                end else begin
                    rx_tmr_d = rx_tmr_q + 1'b1;
                end
            end
            RData: begin
                if (rx_tmr_q == BitLast) begin
                    rx_tmr_d = '0;
                    rx_sh_d  = {rxd_s, rx_sh_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_tmr_d = rx_tmr_q + 1'b1;
                end
            end
            RStop: begin
                if (rx_tmr_q == BitLast) begin
                    rx_tmr_d = '0;
                    rx_gap_d = '0;
                    if (rxd_s) begin
                        rx_state_d = RIdle;
                        if (rx_idx_q == 2'd3) begin
                            nonce_d       = {rx_sh_q, rx_acc_q};
                            nonce_valid_d = 1'b1;
                            rx_idx_d      = '0;
                        end else begin
                            case (rx_idx_q)
                                2'd0:    rx_acc_d[7:0]   = rx_sh_q;
                                2'd1:    rx_acc_d[15:8]  = rx_sh_q;
                                default: rx_acc_d[23:16] = rx_sh_q;
                            endcase
                            rx_idx_d = rx_idx_q + 2'd1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        rx_idx_d    = '0;
                        rx_state_d  = RWaitHi;
                    end
                end else begin
                    rx_tmr_d = rx_tmr_q + 1'b1;
                end
            end
            RWaitHi: begin
                // Hold off until the line returns high so a stuck-low line is not read as starts.
                if (rxd_s) begin
                    rx_state_d = RIdle;
                end
            end
            default: rx_state_d = RIdle;
        endcase
    end

    // RX registers, including the two-flop synchronizer on the asynchronous line.
    always_ff @(posedge hash_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync_q     <= 2'b11;
            rxd_prev_q    <= 1'b1;
            rx_state_q    <= RIdle;
            rx_tmr_q      <= '0;
            rx_bit_q      <= '0;
            rx_sh_q       <= '0;
            rx_idx_q      <= '0;
            rx_acc_q      <= '0;
            rx_gap_q      <= '0;
            nonce_q       <= '0;
            nonce_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            rx_sync_q     <= {rx_sync_q[0], ser_rxd};
            rxd_prev_q    <= rxd_s;
            rx_state_q    <= rx_state_d;
            rx_tmr_q      <= rx_tmr_d;
            rx_bit_q      <= rx_bit_d;
            rx_sh_q       <= rx_sh_d;
            rx_idx_q      <= rx_idx_d;
            rx_acc_q      <= rx_acc_d;
            rx_gap_q      <= rx_gap_d;
            nonce_q       <= nonce_d;
            nonce_valid_q <= nonce_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign nonce        = nonce_q;
    assign nonce_valid  = nonce_valid_q;
    assign rx_frame_err = frame_err_q;

endmodule
